// File: rtl/draw_sched_pkg.sv
// Shared definitions for the draw scheduler: FSM state encoding and the
// default coordinate / colour / delay widths.
package draw_sched_pkg;

  localparam int unsigned DEF_COORD_W  = 10;
  localparam int unsigned DEF_COLOUR_W = 3;
  localparam int unsigned DEF_DLY_W    = 20;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAW,
    INC,
    CHANGE
  } state_t;

endpackage

// File: rtl/draw_scheduler_if.sv
// Control/status bundle between the scheduler FSM and its draw-delay counter.
//   clear  : zero the counter (scheduler -> counter)
//   count  : advance the counter (scheduler -> counter)
//   delay  : terminal value for the current channel (scheduler -> counter)
//   done_c : counter has reached delay, combinational (counter -> scheduler)
interface draw_scheduler_if #(
  parameter int unsigned DLY_W = draw_sched_pkg::DEF_DLY_W
);
  logic             clear;
  logic             count;
  logic [DLY_W-1:0] delay;
  logic             done_c;

  modport master (output clear, count, delay, input done_c);
  modport slave  (input clear, count, delay, output done_c);
endinterface

// File: rtl/draw_delay_counter.sv
// Per-channel draw-delay counter: clear, count up, terminal compare.
// Ports: clk, reset (sync, active-high), ctr (slave side of draw_scheduler_if).
// The counter holds at the terminal value, so it never wraps for a legal delay.
module draw_delay_counter
  import draw_sched_pkg::*;
#(
  parameter int unsigned DLY_W = DEF_DLY_W
) (
  input  logic            clk,
  input  logic            reset,
  draw_scheduler_if.slave ctr
);

  logic [DLY_W-1:0] cnt_q;

  // Counter register
  always_ff @(posedge clk) begin
    if (reset)                         cnt_q <= '0;
    else if (ctr.clear)                cnt_q <= '0;
    else if (ctr.count && !ctr.done_c) cnt_q <= cnt_q + DLY_W'(1);
  end

  assign ctr.done_c = (cnt_q == ctr.delay);

endmodule

// File: rtl/draw_scheduler.sv
// Frame scheduler for up to 8 drawable channels. Each frame runs an erase
// pass (black) then a draw pass over the channels latched active at the frame
// tick, with one game-state advance pulse between the passes.
// Ports: clk, reset (sync, active-high), frame_tick, ch_active, ch_delay,
//   ch_x, ch_y, ch_colour, ch_en (packed per-channel inputs);
//   go (per-channel start pulse), x, y, colour, writeEn (muxed pixel write),
//   inc_enable, iscolour, busy.
// Build option: DRAW_SCHED_PENDING_EN holds a frame_tick that arrives while
//   busy and starts the next frame from IDLE; otherwise such ticks are dropped.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned COORD_W  = DEF_COORD_W,
  parameter int unsigned COLOUR_W = DEF_COLOUR_W,
  parameter int unsigned DLY_W    = DEF_DLY_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic [NUM_CH-1:0]            ch_active,
  input  logic [NUM_CH*DLY_W-1:0]      ch_delay,
  input  logic [NUM_CH*COORD_W-1:0]    ch_x,
  input  logic [NUM_CH*COORD_W-1:0]    ch_y,
  input  logic [NUM_CH*COLOUR_W-1:0]   ch_colour,
  input  logic [NUM_CH-1:0]            ch_en,
  output logic [NUM_CH-1:0]            go,
  output logic [COORD_W-1:0]           x,
  output logic [COORD_W-1:0]           y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         writeEn,
  output logic                         inc_enable,
  output logic                         iscolour,
  output logic                         busy
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              iscolour_q, iscolour_d;
  logic [NUM_CH-1:0] act_q, act_d;
  logic              start_c;
  logic              has_next;
  logic [SEL_W-1:0]  next_sel;
  logic              drawing;

  // Lowest set bit of a channel mask (0 when empty)
  function automatic logic [SEL_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest = SEL_W'(i);
    end
  endfunction

  draw_scheduler_if #(.DLY_W(DLY_W)) ctr_if ();

  draw_delay_counter #(.DLY_W(DLY_W)) u_delay_counter (
    .clk   (clk),
    .reset (reset),
    .ctr   (ctr_if.slave)
  );

  assign ctr_if.clear = (state_q == LOAD);
  assign ctr_if.count = (state_q == DRAW);
  assign ctr_if.delay = ch_delay[int'(sel_q)*DLY_W +: DLY_W];

`ifdef DRAW_SCHED_PENDING_EN
  logic pending_q;

  // Remembers one tick seen while busy; IDLE consumes it
  always_ff @(posedge clk) begin
    if (reset)                  pending_q <= 1'b0;
    else if (state_q == IDLE)   pending_q <= 1'b0;
    else if (frame_tick)        pending_q <= 1'b1;
  end

  assign start_c = frame_tick | pending_q;
`else
  assign start_c = frame_tick;
`endif

  // Next higher latched-active channel above sel
  always_comb begin
    has_next = 1'b0;
    next_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (act_q[i] && (i > int'(sel_q))) begin
        has_next = 1'b1;
        next_sel = SEL_W'(i);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      iscolour_q <= 1'b0;
      act_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      iscolour_q <= iscolour_d;
      act_q      <= act_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    iscolour_d = iscolour_q;
    act_d      = act_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          act_d = ch_active;
          if (|ch_active) begin
            sel_d   = lowest(ch_active);
            state_d = LOAD;
          end else begin
            state_d = INC;
          end
        end
      end
      LOAD: state_d = DRAW;
      DRAW: begin
        if (ctr_if.done_c) begin
          if (has_next) begin
            sel_d   = next_sel;
            state_d = LOAD;
          end else begin
            state_d = iscolour_q ? CHANGE : INC;
          end
        end
      end
      INC: state_d = CHANGE;
      CHANGE: begin
        iscolour_d = !iscolour_q;
        if (!iscolour_q) begin
          // Entering the draw pass
          if (|act_q) begin
            sel_d   = lowest(act_q);
            state_d = LOAD;
          end else begin
            state_d = CHANGE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; pixel path follows sel with zero latency
  assign drawing    = (state_q == LOAD) || (state_q == DRAW);
  assign busy       = (state_q != IDLE);
  assign inc_enable = (state_q == INC);
  assign iscolour   = iscolour_q;
  assign go         = (state_q == LOAD) ? (NUM_CH'(1) << sel_q) : '0;
  assign writeEn    = drawing & ch_en[sel_q];
  assign x          = drawing ? ch_x[int'(sel_q)*COORD_W +: COORD_W] : '0;
  assign y          = drawing ? ch_y[int'(sel_q)*COORD_W +: COORD_W] : '0;
  assign colour     = (drawing && iscolour_q) ?
                      ch_colour[int'(sel_q)*COLOUR_W +: COLOUR_W] : '0;

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: a frame model pushes expected
// go/inc events and per-cycle pixel windows; a negedge monitor pops and checks.
module tb_draw_scheduler;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned DLY_W    = 20;
  localparam int unsigned PW       = 2 + COLOUR_W + 2 * COORD_W;

  typedef struct {
    int kind;  // 0 = go, 1 = inc
    int ch;
    int cyc;
    int pass;
  } ev_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       frame_tick;
  logic [NUM_CH-1:0]          ch_active;
  logic [NUM_CH*DLY_W-1:0]    ch_delay;
  logic [NUM_CH*COORD_W-1:0]  ch_x;
  logic [NUM_CH*COORD_W-1:0]  ch_y;
  logic [NUM_CH*COLOUR_W-1:0] ch_colour;
  logic [NUM_CH-1:0]          ch_en;
  logic [NUM_CH-1:0]          go;
  logic [COORD_W-1:0]         x;
  logic [COORD_W-1:0]         y;
  logic [COLOUR_W-1:0]        colour;
  logic                       writeEn;
  logic                       inc_enable;
  logic                       iscolour;
  logic                       busy;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  busy_cnt = 0;
  bit  mon_on = 1'b0;
  int  dly[NUM_CH];
  int  win[int];
  ev_t sb[$];

  draw_scheduler #(
    .NUM_CH(NUM_CH), .COORD_W(COORD_W), .COLOUR_W(COLOUR_W), .DLY_W(DLY_W)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .ch_active(ch_active),
    .ch_delay(ch_delay), .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_colour),
    .ch_en(ch_en), .go(go), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .inc_enable(inc_enable), .iscolour(iscolour), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame model: pushes events and pixel windows up to relative cycle limit.
  // Returns the busy length of an uninterrupted frame.
  function automatic int build_frame(input int t0, input logic [NUM_CH-1:0] m,
                                     input int limit);
    int t = 1;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m[c]) begin
          if (t <= limit) sb.push_back('{0, c, t0 + t, p});
          for (int k = 0; k <= dly[c] + 1; k++)
            if (t + k <= limit) win[t0 + t + k] = c + 8 * p;
          t += dly[c] + 2;
        end
      end
      if (p == 0) begin
        if (t <= limit) sb.push_back('{1, 0, t0 + t, 0});
        t += 2;
      end
    end
    t += 1;
    return t - 1;
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    ev_t e;
    logic [NUM_CH-1:0] eg;
    logic [PW-1:0] exp_pix, act_pix;
    int c, p;
    cyc = cyc + 1;
    if (mon_on) begin
      if (busy) busy_cnt++;
      if (go !== '0 || inc_enable !== 1'b0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: cyc=%0d go=%b inc=%b, required no event",
                   cyc, go, inc_enable);
        end else begin
          e = sb.pop_front();
          eg = (e.kind == 0) ? (NUM_CH'(1) << e.ch) : '0;
          if ({go, inc_enable, iscolour} !== {eg, e.kind == 1, e.kind == 0 && e.pass == 1}
              || cyc != e.cyc) begin
            bad++;
            $display("FAIL sb_event: cyc=%0d go=%b inc=%b isc=%b, required cyc=%0d go=%b inc=%b isc=%0d",
                     cyc, go, inc_enable, iscolour, e.cyc, eg, e.kind == 1,
                     e.kind == 0 && e.pass == 1);
          end
        end
      end
      total++;
      if (win.exists(cyc)) begin
        c = win[cyc] % 8;
        p = win[cyc] / 8;
        exp_pix = {ch_en[c],
                   (p == 1) ? ch_colour[c*COLOUR_W +: COLOUR_W] : COLOUR_W'(0),
                   ch_x[c*COORD_W +: COORD_W], ch_y[c*COORD_W +: COORD_W], p == 1};
        act_pix = {writeEn, colour, x, y, iscolour};
        if (act_pix !== exp_pix) begin
          bad++;
          $display("FAIL pix: cyc=%0d we/col/x/y/isc=%h, required %h", cyc, act_pix, exp_pix);
        end
      end else if (writeEn !== 1'b0) begin
        bad++;
        $display("FAIL we_idle: cyc=%0d writeEn=%b, required 0", cyc, writeEn);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ch_en = NUM_CH'($urandom);
    end
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2);
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    ch_delay = {DLY_W'(d2), DLY_W'(d1), DLY_W'(d0)};
  endtask

  // Pulses frame_tick for cycle 0; returns with the bench in cycle 1
  task automatic start_frame(input int limit, output int t0, output int len);
    @(posedge clk);
    #1;
    ch_en = NUM_CH'($urandom);
    busy_cnt = 0;
    frame_tick = 1'b1;
    t0 = cyc + 1;
    len = build_frame(t0, ch_active, limit);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic check_end(input string name, input int busy_exp);
    total++;
    if (sb.size() != 0 || busy !== 1'b0 || iscolour !== 1'b0) begin
      bad++;
      $display("FAIL %s_end: pending=%0d busy=%b isc=%b, required 0 0 0",
               name, sb.size(), busy, iscolour);
    end
    total++;
    if (busy_cnt != busy_exp) begin
      bad++;
      $display("FAIL %s_busy: busy cycles=%0d, required %0d", name, busy_cnt, busy_exp);
    end
    sb.delete();
    win.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    frame_tick = 1'b1;
    step(3);
    total++;
    if ({go, inc_enable, writeEn, iscolour, busy} !== '0) begin
      bad++;
      $display("FAIL reset: go/inc/we/isc/busy=%b, required 0", {go, inc_enable, writeEn, iscolour, busy});
    end
    reset = 1'b0;
    frame_tick = 1'b0;
    step(2);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick: busy=%b, required 0", busy);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_full_frame();
    int t0, len;
    ch_active = 3'b111;
    set_delays(30, 2, 10);
    start_frame(1000, t0, len);
    step(len + 10);
    check_end("full", 99);
  endtask

  task automatic test_mask();
    int t0, len;
    ch_active = 3'b101;
    start_frame(1000, t0, len);
    step(9);
    ch_active = 3'b111;  // must not affect the running frame
    step(len + 10);
    check_end("mask", 91);
  endtask

  task automatic test_empty();
    int t0, len;
    ch_active = 3'b000;
    start_frame(1000, t0, len);
    step(len + 6);
    check_end("empty", 3);
  endtask

  task automatic test_zero_delay();
    int t0, len;
    ch_active = 3'b111;
    set_delays(0, 0, 0);
    start_frame(1000, t0, len);
    step(len + 6);
    check_end("zero", 15);
  endtask

  task automatic test_pending();
    int t0, len, len2;
    ch_active = 3'b111;
    set_delays(30, 2, 10);
    start_frame(1000, t0, len);
    step(19);
    frame_tick = 1'b1;
`ifdef DRAW_SCHED_PENDING_EN
    len2 = build_frame(t0 + 100, ch_active, 1000);
`else
    len2 = 0;
`endif
    step(1);
    frame_tick = 1'b0;
    step(200);
    check_end("pending", 99 + len2);
  endtask

  task automatic test_reset_mid();
    int t0, len;
    ch_active = 3'b111;
    set_delays(30, 2, 10);
    start_frame(40, t0, len);
    step(39);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    total++;
    if ({busy, iscolour, writeEn, go, inc_enable} !== '0) begin
      bad++;
      $display("FAIL reset_mid: busy/isc/we/go/inc=%b, required 0",
               {busy, iscolour, writeEn, go, inc_enable});
    end
    step(80);
    check_end("reset_mid", 40);
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    ch_active = '0;
    ch_en = '0;
    ch_x = {10'd300, 10'd155, 10'd17};
    ch_y = {10'd9, 10'd480, 10'd222};
    ch_colour = {3'b010, 3'b101, 3'b111};
    set_delays(30, 2, 10);
    test_reset();
    test_full_frame();
    test_mask();
    test_empty();
    test_zero_delay();
    test_pending();
    test_reset_mid();
    test_zero_delay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
